// File: rtl/armleocpu_writeback.sv
// Writeback arbiter and destination scoreboard: merges ALU and long-unit results into the
// single register-file write port. Optional decode bypass under ARMLEOCPU_WB_BYPASS_EN.
module armleocpu_writeback (
    input  logic        clk,
    input  logic        rst,

    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd_addr,
    input  logic [31:0] alu_rd_wdata,

    input  logic        lu_issue,
    output logic        lu_issue_ready,
    input  logic [4:0]  lu_issue_rd,

    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd_addr,
    input  logic [31:0] lu_rd_wdata,

    output logic        rd_write,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,

    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_hazard,
    output logic        rs2_hazard
`ifdef ARMLEOCPU_WB_BYPASS_EN
    ,
    output logic        rs1_fwd,
    output logic [31:0] rs1_fwd_data,
    output logic        rs2_fwd,
    output logic [31:0] rs2_fwd_data
`endif
);

    // Handshakes: a transfer fires on a rising edge where valid && ready are both high.
    // Valid must not depend on ready; ready may depend on valid and internal state only.

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LU  = 1'b1
    } grant_t;

    grant_t      last_conflict_grant;
    logic [31:0] pending;
    logic [31:0] pending_next;

    logic        alu_eligible;
    logic        lu_eligible;
    logic        conflict;
    logic        grant_lu;
    logic        grant_alu;
    logic        alu_fire;
    logic        lu_fire;
    logic        issue_fire;

    logic        rs1_stage_match;
    logic        rs2_stage_match;

    // Bit 0 is tied to zero, so x0 never stalls, never blocks issue, never raises a hazard.
    always_comb begin
        alu_eligible   = alu_valid && !pending[alu_rd_addr];
        lu_eligible    = lu_valid;
        conflict       = alu_eligible && lu_eligible;
        grant_lu       = lu_eligible && (!alu_eligible || (last_conflict_grant == GRANT_ALU));
        grant_alu      = alu_eligible && !grant_lu;

        alu_ready      = !rst && grant_alu;
        lu_ready       = !rst && grant_lu;
        lu_issue_ready = !rst && !pending[lu_issue_rd];

        alu_fire       = alu_valid && alu_ready;
        lu_fire        = lu_valid && lu_ready;
        issue_fire     = lu_issue && lu_issue_ready;
    end

    // Set after clear so a same-register set/clear in one cycle leaves the bit set.
    always_comb begin
        pending_next = pending;
        if (lu_fire)
            pending_next[lu_rd_addr] = 1'b0;
        if (issue_fire)
            pending_next[lu_issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending             <= 32'd0;
            last_conflict_grant <= GRANT_ALU;
            rd_write            <= 1'b0;
            rd_addr             <= 5'd0;
            rd_wdata            <= 32'd0;
        end else begin
            pending <= pending_next;
            if (conflict)
                last_conflict_grant <= grant_lu ? GRANT_LU : GRANT_ALU;
            if (lu_fire) begin
                rd_write <= (lu_rd_addr != 5'd0);
                rd_addr  <= lu_rd_addr;
                rd_wdata <= lu_rd_wdata;
            end else if (alu_fire) begin
                rd_write <= (alu_rd_addr != 5'd0);
                rd_addr  <= alu_rd_addr;
                rd_wdata <= alu_rd_wdata;
            end else begin
                rd_write <= 1'b0;
            end
        end
    end

    always_comb begin
        rs1_stage_match = rd_write && (rd_addr == rs1_addr) && (rs1_addr != 5'd0);
        rs2_stage_match = rd_write && (rd_addr == rs2_addr) && (rs2_addr != 5'd0);
    end

`ifdef ARMLEOCPU_WB_BYPASS_EN
    always_comb begin
        rs1_hazard   = !rst && pending[rs1_addr];
        rs2_hazard   = !rst && pending[rs2_addr];
        rs1_fwd      = !rst && rs1_stage_match;
        rs2_fwd      = !rst && rs2_stage_match;
        rs1_fwd_data = rd_wdata;
        rs2_fwd_data = rd_wdata;
    end
`else
    // Without bypass the value being written this cycle is not yet readable.
    always_comb begin
        rs1_hazard = !rst && (pending[rs1_addr] || rs1_stage_match);
        rs2_hazard = !rst && (pending[rs2_addr] || rs2_stage_match);
    end
`endif

endmodule

// File: tb/tb_armleocpu_writeback.sv
// Directed bench for armleocpu_writeback: expected writes are queued at acceptance and
// compared when rd_write appears; combinational outputs are checked between edges.
module tb_armleocpu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd_wdata;
    logic        lu_issue;
    logic        lu_issue_ready;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd_addr;
    logic [31:0] lu_rd_wdata;
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_hazard;
    logic        rs2_hazard;
`ifdef ARMLEOCPU_WB_BYPASS_EN
    logic        rs1_fwd;
    logic [31:0] rs1_fwd_data;
    logic        rs2_fwd;
    logic [31:0] rs2_fwd_data;
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];

    armleocpu_writeback dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd_addr(alu_rd_addr), .alu_rd_wdata(alu_rd_wdata),
        .lu_issue(lu_issue), .lu_issue_ready(lu_issue_ready), .lu_issue_rd(lu_issue_rd),
        .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_rd_addr(lu_rd_addr), .lu_rd_wdata(lu_rd_wdata),
        .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard)
`ifdef ARMLEOCPU_WB_BYPASS_EN
        ,
        .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard: every rd_write pulse must match the oldest accepted transfer.
    always @(negedge clk) begin
        if (rd_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, rd_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, rd_addr}, {27'd0, e[36:32]});
                check("wr_data", rd_wdata, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd_addr = 5'd5; alu_rd_wdata = 32'h1234_5678;
        lu_issue = 1'b0; lu_issue_rd = 5'd0;
        lu_valid = 1'b0; lu_rd_addr = 5'd0; lu_rd_wdata = 32'd0;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        settle();

        // Reset held two cycles with ALU valid
        for (int i = 0; i < 2; i++) begin
            check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
            check("rst_lu_issue_ready", {31'd0, lu_issue_ready}, 32'd0);
            check("rst_rs1_hazard", {31'd0, rs1_hazard}, 32'd0);
            check("rst_rs2_hazard", {31'd0, rs2_hazard}, 32'd0);
            step();
            check("rst_rd_write", {31'd0, rd_write}, 32'd0);
            check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        end
        rst = 1'b0;
        settle();
        check("rel_alu_ready", {31'd0, alu_ready}, 32'd1);
        exp_q.push_back({5'd5, 32'h1234_5678});
        step();
        alu_valid = 1'b0;
        settle();
        check("rel_rs1_hazard_x5", {31'd0, rs1_hazard}, {31'd0, !BYP});

        // Issue x4, then continuous conflict ALU x3 vs LU x4
        lu_issue = 1'b1; lu_issue_rd = 5'd4;
        settle();
        check("issue_x4_ready", {31'd0, lu_issue_ready}, 32'd1);
        step();
        lu_issue = 1'b0;
        alu_valid = 1'b1; alu_rd_addr = 5'd3; alu_rd_wdata = 32'hA000_0000;
        lu_valid  = 1'b1; lu_rd_addr  = 5'd4; lu_rd_wdata  = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("cf_lu_ready", {31'd0, lu_ready}, {31'd0, (i % 2) == 0});
            check("cf_alu_ready", {31'd0, alu_ready}, {31'd0, (i % 2) == 1});
            if ((i % 2) == 0) exp_q.push_back({lu_rd_addr, lu_rd_wdata});
            else              exp_q.push_back({alu_rd_addr, alu_rd_wdata});
            step();
            check("cf_rd_write", {31'd0, rd_write}, 32'd1);
            if ((i % 2) == 0) lu_rd_wdata  = 32'hB000_0000 + 32'(i + 1);
            else              alu_rd_wdata = 32'hA000_0000 + 32'(i + 1);
        end
        alu_valid = 1'b0; lu_valid = 1'b0;
        step();

        // Scoreboard on x7
        lu_issue = 1'b1; lu_issue_rd = 5'd7;
        settle();
        check("issue_x7_ready", {31'd0, lu_issue_ready}, 32'd1);
        step();
        lu_issue = 1'b0;
        rs1_addr = 5'd7;
        alu_valid = 1'b1; alu_rd_addr = 5'd7; alu_rd_wdata = 32'h0000_0077;
        settle();
        check("x7_hazard", {31'd0, rs1_hazard}, 32'd1);
        check("x7_alu_waw", {31'd0, alu_ready}, 32'd0);
        lu_issue = 1'b1;
        settle();
        check("x7_reissue_blocked", {31'd0, lu_issue_ready}, 32'd0);
        lu_issue = 1'b0;
        step();
        check("x7_hazard_hold", {31'd0, rs1_hazard}, 32'd1);
        check("x7_alu_waw_hold", {31'd0, alu_ready}, 32'd0);
        lu_valid = 1'b1; lu_rd_addr = 5'd7; lu_rd_wdata = 32'h7777_0000;
        settle();
        check("x7_lu_ready", {31'd0, lu_ready}, 32'd1);
        check("x7_alu_still_held", {31'd0, alu_ready}, 32'd0);
        exp_q.push_back({5'd7, 32'h7777_0000});
        step();
        lu_valid = 1'b0;
        settle();
        check("x7_alu_released", {31'd0, alu_ready}, 32'd1);
        check("x7_issue_ready_again", {31'd0, lu_issue_ready}, 32'd1);
        check("x7_hazard_after_retire", {31'd0, rs1_hazard}, {31'd0, !BYP});
`ifdef ARMLEOCPU_WB_BYPASS_EN
        check("x7_fwd", {31'd0, rs1_fwd}, 32'd1);
        check("x7_fwd_data", rs1_fwd_data, 32'h7777_0000);
`endif
        exp_q.push_back({5'd7, 32'h0000_0077});
        step();
        alu_valid = 1'b0;
        settle();
        check("x7_hazard_alu_stage", {31'd0, rs1_hazard}, {31'd0, !BYP});
        step();
        check("x7_hazard_clear", {31'd0, rs1_hazard}, 32'd0);

        // x0 destination
        alu_valid = 1'b1; alu_rd_addr = 5'd0; alu_rd_wdata = 32'hFFFF_FFFF;
        lu_issue = 1'b1; lu_issue_rd = 5'd0;
        settle();
        check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("x0_issue_ready", {31'd0, lu_issue_ready}, 32'd1);
        step();
        alu_valid = 1'b0; lu_issue = 1'b0;
        check("x0_no_write", {31'd0, rd_write}, 32'd0);
        alu_valid = 1'b1;
        lu_issue = 1'b1;
        settle();
        check("x0_alu_not_stalled", {31'd0, alu_ready}, 32'd1);
        check("x0_issue_again", {31'd0, lu_issue_ready}, 32'd1);
        step();
        alu_valid = 1'b0; lu_issue = 1'b0;

        // Bypass / output-stage hazard on x9
        alu_valid = 1'b1; alu_rd_addr = 5'd9; alu_rd_wdata = 32'h0000_CAFE;
        settle();
        check("x9_alu_ready", {31'd0, alu_ready}, 32'd1);
        exp_q.push_back({5'd9, 32'h0000_CAFE});
        step();
        alu_valid = 1'b0; rs2_addr = 5'd9;
        settle();
        check("x9_rs2_hazard", {31'd0, rs2_hazard}, {31'd0, !BYP});
`ifdef ARMLEOCPU_WB_BYPASS_EN
        check("x9_rs2_fwd", {31'd0, rs2_fwd}, 32'd1);
        check("x9_rs2_fwd_data", rs2_fwd_data, 32'h0000_CAFE);
`endif
        step();
        check("x9_rs2_hazard_gone", {31'd0, rs2_hazard}, 32'd0);

        // Reset mid-flight
        lu_issue = 1'b1; lu_issue_rd = 5'd10;
        alu_valid = 1'b1; alu_rd_addr = 5'd11; alu_rd_wdata = 32'h0000_1111;
        settle();
        check("mf_issue_ready", {31'd0, lu_issue_ready}, 32'd1);
        check("mf_alu_ready", {31'd0, alu_ready}, 32'd1);
        exp_q.push_back({5'd11, 32'h0000_1111});
        step();
        lu_issue = 1'b0; alu_valid = 1'b0;
        lu_valid = 1'b1; lu_rd_addr = 5'd10; lu_rd_wdata = 32'h0000_DEAD;
        rs1_addr = 5'd10;
        settle();
        check("mf_pending_hazard", {31'd0, rs1_hazard}, 32'd1);
        rst = 1'b1;
        settle();
        check("mf_rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        check("mf_rst_hazard", {31'd0, rs1_hazard}, 32'd0);
        step();
        rst = 1'b0; lu_valid = 1'b0;
        settle();
        check("mf_rd_write_cleared", {31'd0, rd_write}, 32'd0);
        check("mf_rd_addr_cleared", {27'd0, rd_addr}, 32'd0);
        check("mf_issue_x10_ready", {31'd0, lu_issue_ready}, 32'd1);
        check("mf_hazard_cleared", {31'd0, rs1_hazard}, 32'd0);
        step();
        step();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
